// File: rtl/reaction_timer.sv
// Reaction-time measurement datapath.
// Follows an external test controller's state and provides a pseudo-random
// pre-start delay, a millisecond reaction counter with saturation/overflow,
// and a "counters cleared" status flag.
module reaction_timer #(
  parameter int CLK_PER_MS   = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int MAX_TIME     = 999
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] machine_state,
  output logic [9:0] react_time,
  output logic       signal_start,
  output logic       signal_overflow,
  output logic       signal_cleared
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CLR_CNT1 = 3'd2,
    ST_START    = 3'd3,
    ST_STORAGE  = 3'd4,
    ST_CLR_CNT2 = 3'd5,
    ST_AVERAGE  = 3'd6,
    ST_COMPARE  = 3'd7
  } state_e;

  localparam int              PW         = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [11:0]     DELAY_MIN  = 12'(DELAY_MIN_MS);
  localparam logic [9:0]      MAX_CNT    = 10'(MAX_TIME);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  state_e          w_state;
  state_e          r_prev_state;
  logic            w_first;
  logic            w_active;
  logic            w_in_clr;
  logic            w_tick;
  logic            w_delay_hit;
  logic            w_lfsr_fb;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_cur;
  logic [15:0]     r_lfsr;
  logic [11:0]     r_delay_target;
  logic [11:0]     r_delay_cnt;
  logic            r_delay_done;
  logic [9:0]      r_react_cnt;
  logic            r_start;
  logic            r_ovf;
  logic            r_cleared;

  assign w_state  = state_e'(machine_state);
  assign w_first  = (w_state != r_prev_state);
  assign w_active = (w_state == ST_WAIT) || (w_state == ST_START);
  assign w_in_clr = (w_state == ST_CLR_CNT1) || (w_state == ST_CLR_CNT2);

  // The prescaler reads as zero on the entry cycle so every WAIT/START dwell
  // starts a fresh millisecond, even on a direct WAIT<->START jump.
  assign w_presc_cur = (w_active && !w_first) ? r_presc : '0;
  assign w_tick      = w_active && (w_presc_cur == PRESC_LAST);

  // Taps 16,14,13,11 (1-based) of a Fibonacci LFSR shifting toward the MSB.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_delay_hit = (w_state == ST_WAIT) && !w_first && w_tick && !r_delay_done &&
                       ((r_delay_cnt + 12'd1) == r_delay_target);

  // Free-running LFSR and previous-state register for entry detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr       <= LFSR_SEED;
      r_prev_state <= ST_IDLE;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
      r_prev_state <= w_state;
    end
  end

  // Millisecond prescaler, running only inside WAIT or START.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (!w_active || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_presc_cur + PW'(1);
    end
  end

  // Random pre-start delay: armed on WAIT entry, fires once per WAIT dwell.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_delay_target <= '0;
      r_delay_cnt    <= '0;
      r_delay_done   <= 1'b0;
    end else if (w_state == ST_IDLE) begin
      r_delay_cnt  <= '0;
      r_delay_done <= 1'b0;
    end else if (w_state == ST_WAIT) begin
      if (w_first) begin
        r_delay_target <= DELAY_MIN + {1'b0, r_lfsr[10:0]};
        r_delay_cnt    <= '0;
        r_delay_done   <= 1'b0;
      end else if (w_tick && !r_delay_done) begin
        r_delay_cnt <= r_delay_cnt + 12'd1;
        if (w_delay_hit) r_delay_done <= 1'b1;
      end
    end
  end

  // Reaction counter with saturation; overflow latches one cycle after saturation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_react_cnt <= '0;
      r_ovf       <= 1'b0;
    end else if ((w_state == ST_IDLE) || w_in_clr) begin
      r_react_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if ((w_state == ST_START) && w_tick && (r_react_cnt != MAX_CNT)) begin
        r_react_cnt <= r_react_cnt + 10'd1;
      end
      if (r_react_cnt == MAX_CNT) r_ovf <= 1'b1;
    end
  end

  // Registered status outputs: start pulse and cleared level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start   <= 1'b0;
      r_cleared <= 1'b0;
    end else begin
      r_start   <= w_delay_hit;
      r_cleared <= w_in_clr;
    end
  end

  assign react_time      = r_react_cnt;
  assign signal_start    = r_start;
  assign signal_overflow = r_ovf;
  assign signal_cleared  = r_cleared;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: a time-since-entry reference model
// is compared against the outputs every cycle, plus directed literal checks.
module tb_reaction_timer;

  localparam int N    = 4;
  localparam int DMIN = 2;
  localparam int MAXT = 10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CLR1    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_STORAGE = 3'd4;
  localparam logic [2:0] S_CLR2    = 3'd5;
  localparam logic [2:0] S_AVERAGE = 3'd6;
  localparam logic [2:0] S_COMPARE = 3'd7;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] machine_state;
  logic [9:0] react_time;
  logic       signal_start;
  logic       signal_overflow;
  logic       signal_cleared;

  int checks = 0;
  int errors = 0;
  bit m_run  = 1'b0;

  always #5 clk = ~clk;

  reaction_timer #(
    .CLK_PER_MS  (N),
    .DELAY_MIN_MS(DMIN),
    .MAX_TIME    (MAXT)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .machine_state  (machine_state),
    .react_time     (react_time),
    .signal_start   (signal_start),
    .signal_overflow(signal_overflow),
    .signal_cleared (signal_cleared)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference model: tracks time since state entry and derives ticks, the
  // start pulse and the counter from it arithmetically.
  logic [15:0] m_lfsr;
  logic [2:0]  m_prev;
  int          m_t;
  int          m_target;
  int          m_react;
  bit          m_ovf;
  bit          m_start;
  bit          m_cleared;

  always @(posedge clk or negedge rstn) begin
    int  t;
    bit  tick;
    if (!rstn) begin
      m_lfsr    = 16'hACE1;
      m_prev    = S_IDLE;
      m_t       = 0;
      m_target  = 0;
      m_react   = 0;
      m_ovf     = 1'b0;
      m_start   = 1'b0;
      m_cleared = 1'b0;
    end else begin
      t    = (machine_state != m_prev) ? 0 : m_t;
      tick = ((machine_state == S_WAIT) || (machine_state == S_START)) && ((t % N) == N - 1);
      if ((machine_state == S_WAIT) && (t == 0)) m_target = DMIN + int'(m_lfsr[10:0]);
      m_start   = (machine_state == S_WAIT) && (t == m_target * N - 1);
      m_cleared = (machine_state == S_CLR1) || (machine_state == S_CLR2);
      if ((machine_state == S_IDLE) || m_cleared) begin
        m_react = 0;
        m_ovf   = 1'b0;
      end else begin
        if (m_react == MAXT) m_ovf = 1'b1;
        if ((machine_state == S_START) && tick && (m_react < MAXT)) m_react++;
      end
      m_prev = machine_state;
      m_t    = t + 1;
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_run) begin
      check("react_time", int'(react_time), m_react);
      check("signal_overflow", int'(signal_overflow), int'(m_ovf));
      check("signal_start", int'(signal_start), int'(m_start));
      check("signal_cleared", int'(signal_cleared), int'(m_cleared));
    end
  end

  // Hold a state for a number of cycles; called on a falling edge.
  task automatic go(input logic [2:0] s, input int cycles);
    machine_state = s;
    repeat (cycles) @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #990000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int waited;
    int first_pulse;
    int pulses;
    int clr_hi;
    int k_sat;
    int k_ovf;
    bit found;
    logic [2:0] s;
    int d;

    rstn          = 1'b0;
    machine_state = S_IDLE;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    m_run = 1'b1;

    // Reset state
    check("rst_react_time", int'(react_time), 0);
    check("rst_overflow", int'(signal_overflow), 0);
    check("rst_start", int'(signal_start), 0);
    check("rst_cleared", int'(signal_cleared), 0);

    // WAIT with lfsr[10:0]=3 -> target 5 -> pulse 20 cycles after entry, once
    waited = 0;
    while ((m_lfsr[10:0] != 11'd3) && (waited < 66000)) begin
      @(negedge clk);
      waited++;
    end
    check("lfsr_low_at_wait_entry", int'(dut.r_lfsr[10:0]), 3);
    machine_state = S_WAIT;
    first_pulse   = -1;
    pulses        = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (signal_start) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    check("start_latency", first_pulse, 20);
    check("start_pulse_count", pulses, 1);

    // CLR_CNT1 held 3 cycles
    machine_state = S_CLR1;
    clr_hi        = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (signal_cleared) clr_hi++;
    end
    check("cleared_high_cycles", clr_hi, 3);
    check("clr_react_time", int'(react_time), 0);
    check("clr_overflow", int'(signal_overflow), 0);

    // START for 29 cycles then STORAGE/AVERAGE -> 7 ms
    machine_state = S_START;
    @(negedge clk);
    check("cleared_low_after_exit", int'(signal_cleared), 0);
    repeat (28) @(negedge clk);
    go(S_STORAGE, 3);
    check("storage_react_time", int'(react_time), 7);
    go(S_AVERAGE, 3);
    check("average_react_time", int'(react_time), 7);

    // START for 60 cycles -> saturate at 10, overflow one cycle later
    go(S_CLR2, 2);
    machine_state = S_START;
    k_sat = -1;
    k_ovf = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((react_time == 10'(MAXT)) && (k_sat < 0)) k_sat = k;
      if (signal_overflow && (k_ovf < 0)) k_ovf = k;
    end
    check("saturate_cycle", k_sat, 40);
    check("overflow_after_saturate", k_ovf - k_sat, 1);
    check("sat_react_time", int'(react_time), MAXT);
    go(S_STORAGE, 5);
    check("storage_overflow_held", int'(signal_overflow), 1);
    check("storage_react_saturated", int'(react_time), MAXT);
    go(S_CLR2, 2);
    check("clr2_overflow_cleared", int'(signal_overflow), 0);
    check("clr2_react_cleared", int'(react_time), 0);

    // Reset mid-START at react_time = 6
    machine_state = S_START;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (react_time == 10'd6) found = 1'b1;
    end
    check("reached_react_6", int'(found), 1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_react_time", int'(react_time), 0);
    check("midrst_overflow", int'(signal_overflow), 0);
    check("midrst_start", int'(signal_start), 0);
    check("midrst_cleared", int'(signal_cleared), 0);
    machine_state = S_IDLE;
    @(negedge clk);
    #2 rstn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (signal_start) pulses++;
    end
    check("no_start_after_reset", pulses, 0);

    // WAIT abandoned after 8 cycles (target >= 3 so no expiry inside 8 cycles)
    waited = 0;
    while ((m_lfsr[10:0] == 11'd0) && (waited < 100)) begin
      @(negedge clk);
      waited++;
    end
    machine_state = S_WAIT;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (signal_start) pulses++;
    end
    check("abandon_delay_done", int'(dut.r_delay_done), 0);
    machine_state = S_IDLE;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (signal_start) pulses++;
    end
    check("abandon_no_start", pulses, 0);
    check("abandon_delay_done_idle", int'(dut.r_delay_done), 0);

    // Randomized state sequences, occasional resets; model checks every cycle
    for (int i = 0; i < 80; i++) begin
      s = 3'($urandom_range(0, 7));
      d = (s == S_WAIT) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 70));
      if ($urandom_range(0, 19) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
      end
      go(s, d);
    end

    // A short-target WAIT in the random mix so the pulse path is re-exercised
    waited = 0;
    while ((m_lfsr[10:0] > 11'd4) && (waited < 66000)) begin
      @(negedge clk);
      waited++;
    end
    go(S_IDLE, 1);
    go(S_WAIT, 60);
    go(S_START, 45);
    go(S_COMPARE, 5);
    go(S_IDLE, 3);

    m_run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
